// File: rtl/matrix_unloader.sv
// Consumer end of the transposer output handshake: captures the producer's
// result matrix when it reports ready, then streams it row-major over valid/ready.
module matrix_unloader #(
  parameter  int IL   = 8,
  parameter  int FL   = 12,
  parameter  int ROWS = 4,
  parameter  int COLS = 4,
  localparam int W    = IL + FL,
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [1:0]                       src_state,
  input  logic [ROWS-1:0][COLS-1:0][W-1:0] in,
  output logic                             output_taken,
  output logic signed [W-1:0]              out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [RW-1:0]                    out_row,
  output logic [CW-1:0]                    out_col,
  output logic                             out_last,
  output logic [1:0]                       state,
  output logic [15:0]                      frame_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    STREAM = 2'b01
  } state_t;

  localparam logic [1:0]    SRC_READY = 2'b10;
  localparam logic [RW-1:0] ROW_MAX   = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX   = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_ONE   = RW'(1);
  localparam logic [CW-1:0] COL_ONE   = CW'(1);

  state_t                           state_r;
  logic [ROWS-1:0][COLS-1:0][W-1:0] cap_r;
  logic [RW-1:0]                    next_row_s;
  logic [CW-1:0]                    next_col_s;
  logic                             at_last_s;
  logic                             accept_s;

  // Row-major successor of the current element index.
  always_comb begin
    next_row_s = out_row;
    next_col_s = out_col;
    if (out_col == COL_MAX) begin
      next_col_s = '0;
      next_row_s = out_row + ROW_ONE;
    end else begin
      next_col_s = out_col + COL_ONE;
      next_row_s = out_row;
    end
  end

  assign at_last_s = (out_row == ROW_MAX) && (out_col == COL_MAX);
  assign accept_s  = out_valid && out_ready;
  assign out_last  = out_valid && at_last_s;
  assign state     = state_r;

  // Capture/stream controller; every output except out_last is registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      cap_r        <= '0;
      output_taken <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_row      <= '0;
      out_col      <= '0;
      frame_count  <= 16'd0;
    end else begin
      output_taken <= 1'b0;
      case (state_r)
        IDLE: begin
          if (src_state == SRC_READY) begin
            cap_r        <= in;
            out_data     <= in[0][0];
            out_row      <= '0;
            out_col      <= '0;
            out_valid    <= 1'b1;
            output_taken <= 1'b1;
            state_r      <= STREAM;
          end else begin
            out_valid <= 1'b0;
          end
        end
        STREAM: begin
          // src_state and in are deliberately ignored until the frame drains.
          if (accept_s) begin
            if (at_last_s) begin
              out_valid   <= 1'b0;
              out_row     <= '0;
              out_col     <= '0;
              frame_count <= frame_count + 16'd1;
              state_r     <= IDLE;
            end else begin
              out_row  <= next_row_s;
              out_col  <= next_col_s;
              out_data <= cap_r[next_row_s][next_col_s];
            end
          end else begin
            out_valid <= out_valid;
          end
        end
        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
          out_row   <= '0;
          out_col   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_unloader.sv
// Scoreboard bench for matrix_unloader: beats are queued at capture time and
// compared as the unloader presents them.
module tb_matrix_unloader;
  localparam int IL = 8, FL = 12, W = IL + FL, ROWS = 4, COLS = 4;

  logic                             clk = 1'b0;
  logic                             reset = 1'b0;
  logic [1:0]                       src_state = 2'b00;
  logic [ROWS-1:0][COLS-1:0][W-1:0] in_m = '0;
  logic                             output_taken;
  logic signed [W-1:0]              out_data;
  logic                             out_valid;
  logic                             out_ready = 1'b0;
  logic [1:0]                       out_row;
  logic [1:0]                       out_col;
  logic                             out_last;
  logic [1:0]                       state;
  logic [15:0]                      frame_count;

  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   row;
    logic [1:0]   col;
    logic         last;
  } beat_t;

  beat_t       sb[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_frames = 16'd0;

  matrix_unloader #(.IL(IL), .FL(FL), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .reset(reset), .src_state(src_state), .in(in_m),
    .output_taken(output_taken), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_row(out_row), .out_col(out_col),
    .out_last(out_last), .state(state), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic fill(input int kind);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        in_m[r][c] = W'(16 * r + c);
    if (kind == 1) begin
      in_m[0][0] = 20'hFFFFF;
      in_m[3][3] = 20'h80000;
    end
  endtask

  task automatic push_frame();
    beat_t b;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        b.data = in_m[r][c];
        b.row  = 2'(r);
        b.col  = 2'(c);
        b.last = (r == ROWS - 1) && (c == COLS - 1);
        sb.push_back(b);
      end
  endtask

  // Called at a negedge while idle; returns at the negedge after the capture edge.
  task automatic capture(input string name, input bit keep_src);
    src_state = 2'b10;
    push_frame();
    @(negedge clk);
    total++;
    if (output_taken !== 1'b1 || out_valid !== 1'b1 || state !== 2'b01) begin
      bad++;
      $display("FAIL %s_capture: taken=%b valid=%b state=%b, want 1 1 01",
               name, output_taken, out_valid, state);
    end
    if (!keep_src) src_state = 2'b00;
  endtask

  // mode 0: ready high, 1: alternating 1,0,..., 2: random. Stops after max_acc accepts.
  task automatic drain(input string name, input int mode, input int max_acc);
    beat_t got;
    int    acc = 0;
    for (int cyc = 0; cyc < 400 && sb.size() > 0 && acc < max_acc; cyc++) begin
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      got = {out_data, out_row, out_col, out_last};
      total++;
      if (!out_valid) begin
        bad++;
        $display("FAIL %s_valid: cycle %0d out_valid=0, want 1", name, cyc);
      end else if (got !== sb[0]) begin
        bad++;
        $display("FAIL %s_beat: got data=%h r=%0d c=%0d last=%b, want data=%h r=%0d c=%0d last=%b",
                 name, got.data, got.row, got.col, got.last,
                 sb[0].data, sb[0].row, sb[0].col, sb[0].last);
      end
      if (cyc > 0 && output_taken !== 1'b0) begin
        total++;
        bad++;
        $display("FAIL %s_taken: output_taken=1 during stream, want 0", name);
      end
      if (out_valid && out_ready) begin
        void'(sb.pop_front());
        acc++;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    if (acc < max_acc && sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: %0d beats left, want 0", name, sb.size());
    end
    if (sb.size() == 0) begin
      exp_frames = exp_frames + 16'd1;
      total++;
      if (out_valid !== 1'b0 || state !== 2'b00 || frame_count !== exp_frames) begin
        bad++;
        $display("FAIL %s_end: valid=%b state=%b frames=%0d, want 0 00 %0d",
                 name, out_valid, state, frame_count, exp_frames);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({output_taken, out_valid, out_data, out_row, out_col, out_last, state, frame_count} !== '0) begin
      bad++;
      $display("FAIL reset: taken=%b valid=%b data=%h row=%0d col=%0d last=%b state=%b frames=%0d, want all 0",
               output_taken, out_valid, out_data, out_row, out_col, out_last, state, frame_count);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    fill(0);
    capture("basic", 1'b0);
    drain("basic", 0, 16);
  endtask

  task automatic test_backpressure();
    fill(0);
    capture("bp", 1'b0);
    drain("bp", 1, 16);
    fill(1);
    capture("bp_rand", 1'b0);
    drain("bp_rand", 2, 16);
  endtask

  task automatic test_ignore_src_back_to_back();
    fill(0);
    capture("ignore", 1'b1);
    in_m = {ROWS * COLS{20'h7FFFF}};
    drain("ignore", 0, 16);
    push_frame();
    @(negedge clk);
    total++;
    if (output_taken !== 1'b1 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL b2b_capture: taken=%b valid=%b, want 1 1", output_taken, out_valid);
    end
    src_state = 2'b00;
    drain("b2b", 0, 16);
  endtask

  task automatic test_signed();
    fill(1);
    capture("signed", 1'b0);
    drain("signed", 0, 16);
  endtask

  task automatic test_reset_midstream();
    fill(0);
    capture("mid", 1'b0);
    drain("mid", 0, 5);
    #2 reset = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || state !== 2'b00 || frame_count !== 16'd0 || out_data !== '0) begin
      bad++;
      $display("FAIL mid_reset: valid=%b state=%b frames=%0d data=%h, want 0 00 0 0",
               out_valid, state, frame_count, out_data);
    end
    sb.delete();
    exp_frames = 16'd0;
    src_state = 2'b10;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (state !== 2'b00 || output_taken !== 1'b0) begin
      bad++;
      $display("FAIL mid_hold: state=%b taken=%b, want 00 0", state, output_taken);
    end
    fill(0);
    reset = 1'b1;
    capture("mid_restart", 1'b0);
    drain("mid_restart", 0, 16);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_ignore_src_back_to_back();
    test_signed();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
